// File: rtl/circ_resp_checker.sv
// Exhaustive-test response checker: walks every input vector, waits for the
// circuit under test to settle, compares its response against a packed golden
// truth table and accumulates a mismatch count, first failing vector and MISR.
module circ_resp_checker #(
    parameter int unsigned                   N_IN     = 4,
    parameter int unsigned                   N_OUT    = 3,
    parameter int unsigned                   SETTLE   = 2,
    parameter logic [N_OUT*(2**N_IN)-1:0]    EXPECTED = '0
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    output logic [N_IN-1:0]   vec,
    input  logic [N_OUT-1:0]  resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_err,
    output logic [7:0]        signature
);

    // Counter wide enough to reach SETTLE (it briefly holds SETTLE on exit).
    localparam int unsigned     CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] first_q, first_d;
    logic [7:0]      sig_q, sig_d;
    logic            pass_q, pass_d;

    logic [N_OUT-1:0] exp_resp;
    logic [7:0]       resp_ext;
    logic [7:0]       sig_next;
    logic             mismatch;
    int unsigned      exp_idx;

    // Golden lookup for the current vector and MISR step over the live response.
    always_comb begin
        exp_idx  = N_OUT * 32'(vec_q);
        exp_resp = EXPECTED[exp_idx +: N_OUT];
        mismatch = (resp != exp_resp);
        resp_ext = '0;
        resp_ext[N_OUT-1:0] = resp;
        sig_next = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? 8'h1D : 8'h00) ^ resp_ext;
    end

    // Next-state and result-update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        first_d = first_q;
        sig_d   = sig_q;
        pass_d  = pass_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWait;
                    vec_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    sig_d   = 8'h00;
                    pass_d  = 1'b0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                    if (err_q == '0) begin
                        first_d = vec_q;
                    end
                end
                sig_d = sig_next;
                if (vec_q == LAST_VEC) begin
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    cnt_d   = '0;
                    state_d = StWait;
                end
            end
            StDone: begin
                pass_d  = (err_q == '0);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers; reset aborts any run immediately.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            sig_q   <= 8'h00;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            first_q <= first_d;
            sig_q   <= sig_d;
            pass_q  <= pass_d;
        end
    end

    // Output decode.
    always_comb begin
        busy      = (state_q == StWait) || (state_q == StSample);
        done      = (state_q == StDone);
        vec       = vec_q;
        err_count = err_q;
        first_err = first_q;
        signature = sig_q;
        pass      = pass_q;
    end

endmodule

// File: tb/tb_circ_resp_checker.sv
// Bench for circ_resp_checker: a golden gate-level function drives three
// instances (default settle with fault injection, all-fail table, SETTLE=1
// with early-settle glitches); results are compared to a per-run model.
module tb_circ_resp_checker;

    function automatic logic [2:0] gold_fn(input logic [3:0] v);
        return {(v[0] & v[1]) | v[2], ^v, ~(v[1] & v[3])};
    endfunction

    function automatic logic [47:0] build_gold();
        logic [47:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) t[3*i +: 3] = gold_fn(4'(i));
        return t;
    endfunction

    localparam logic [47:0] GOLD = build_gold();

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    // Main instance, default SETTLE, golden table, injectable faults.
    logic        start_m = 1'b0;
    logic [3:0]  vec_m;
    logic [2:0]  resp_m;
    logic        busy_m, done_m, pass_m;
    logic [4:0]  err_m;
    logic [3:0]  first_m;
    logic [7:0]  sig_m;
    logic [47:0] fault_m = '0;
    always_comb resp_m = gold_fn(vec_m) ^ fault_m[3*vec_m +: 3];

    circ_resp_checker #(.N_IN(4), .N_OUT(3), .SETTLE(2), .EXPECTED(GOLD)) dut (
        .clk(clk), .reset_b(reset_b), .start(start_m), .vec(vec_m), .resp(resp_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .err_count(err_m),
        .first_err(first_m), .signature(sig_m)
    );

    // All-fail instance: table all ones, response stuck at zero.
    logic        start_f = 1'b0;
    logic [3:0]  vec_f;
    logic [2:0]  resp_f;
    logic        busy_f, done_f, pass_f;
    logic [4:0]  err_f;
    logic [3:0]  first_f;
    logic [7:0]  sig_f;
    assign resp_f = 3'b000;

    circ_resp_checker #(.N_IN(4), .N_OUT(3), .SETTLE(2), .EXPECTED(48'hFFFF_FFFF_FFFF)) dut_ff (
        .clk(clk), .reset_b(reset_b), .start(start_f), .vec(vec_f), .resp(resp_f),
        .busy(busy_f), .done(done_f), .pass(pass_f), .err_count(err_f),
        .first_err(first_f), .signature(sig_f)
    );

    // SETTLE=1 instance; response is corrupted during each first settle cycle.
    logic        start_s = 1'b0;
    logic        glitch = 1'b0;
    logic [3:0]  vec_s;
    logic [2:0]  resp_s;
    logic        busy_s, done_s, pass_s;
    logic [4:0]  err_s;
    logic [3:0]  first_s;
    logic [7:0]  sig_s;
    always_comb resp_s = glitch ? ~gold_fn(vec_s) : gold_fn(vec_s);

    circ_resp_checker #(.N_IN(4), .N_OUT(3), .SETTLE(1), .EXPECTED(GOLD)) dut_s1 (
        .clk(clk), .reset_b(reset_b), .start(start_s), .vec(vec_s), .resp(resp_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
        .first_err(first_s), .signature(sig_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Whole-run model: count nonzero fault slots, first one, MISR of responses.
    task automatic model(input logic [47:0] fault, output int e, output int f,
                         output logic [7:0] s);
        logic [2:0] r;
        e = 0;
        f = 0;
        s = 8'h00;
        for (int v = 0; v < 16; v++) begin
            r = gold_fn(4'(v)) ^ fault[3*v +: 3];
            if (fault[3*v +: 3] != 3'b000) begin
                if (e == 0) f = v;
                e++;
            end
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {5'b0, r};
        end
    endtask

    task automatic run_main(input string tag, input logic [47:0] fault, input int ee,
                            input int ef, input logic ep, input logic [7:0] es);
        int c;
        fault_m = fault;
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        c = 1;
        while (!done_m && c < 120) begin
            tick();
            c++;
        end
        check({tag, " done_cycle"}, c, 49);
        check({tag, " busy_at_done"}, busy_m, 0);
        check({tag, " err_count"}, err_m, ee);
        if (ee != 0) check({tag, " first_err"}, first_m, ef);
        check({tag, " signature"}, sig_m, es);
        tick();
        check({tag, " pass"}, pass_m, ep);
        check({tag, " done_pulse"}, done_m, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " vec"}, vec_m, 0);
        check({tag, " busy"}, busy_m, 0);
        check({tag, " done"}, done_m, 0);
        check({tag, " pass"}, pass_m, 0);
        check({tag, " err"}, err_m, 0);
        check({tag, " first"}, first_m, 0);
        check({tag, " sig"}, sig_m, 0);
    endtask

    typedef struct {
        logic [47:0] fault;
        int          err;
        int          first;
        logic        pass_exp;
    } vec_rec_t;

    vec_rec_t tbl[4];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int e, f, c, ndone, bad;
        logic [7:0] s, s_gold;
        logic [47:0] fault;

        tbl[0] = '{48'h0, 0, 0, 1'b1};
        tbl[1] = '{48'h1 << 15, 1, 5, 1'b0};
        tbl[2] = '{48'h7 | (48'h2 << 45), 2, 0, 1'b0};
        tbl[3] = '{(48'h4 << 27) | (48'h1 << 36), 2, 9, 1'b0};
        model(48'h0, e, f, s_gold);

        #12;
        check_reset_vals("por");
        reset_b = 1'b1;
        tick();

        // Table-driven fault patterns.
        for (int i = 0; i < 4; i++) begin
            model(tbl[i].fault, e, f, s);
            run_main($sformatf("tbl%0d", i), tbl[i].fault, tbl[i].err, tbl[i].first,
                     tbl[i].pass_exp, s);
        end

        // Random sparse faults against the model.
        for (int k = 0; k < 6; k++) begin
            fault = '0;
            for (int v = 0; v < 16; v++)
                if ($urandom_range(0, 3) == 0) fault[3*v +: 3] = 3'($urandom_range(1, 7));
            model(fault, e, f, s);
            run_main($sformatf("rnd%0d", k), fault, e, f, (e == 0), s);
        end

        // Start pulses while busy and during DONE are ignored.
        fault_m = '0;
        start_m = 1'b1;
        tick();
        ndone = 0;
        for (c = 1; c <= 70; c++) begin
            start_m = (c == 10 || c == 30 || c == 49);
            if (done_m) ndone++;
            if (c == 49) check("ign done_cycle49", done_m, 1);
            tick();
        end
        start_m = 1'b0;
        check("ign single_done", ndone, 1);
        check("ign idle", busy_m, 0);
        check("ign err", err_m, 0);
        check("ign pass", pass_m, 1);
        check("ign vec_hold", vec_m, 15);
        check("ign sig_hold", sig_m, s_gold);
        // Asynchronous reset between edges clears held results.
        #2 reset_b = 1'b0;
        #1 check_reset_vals("async_rst");
        #1 reset_b = 1'b1;
        tick();

        // Level-held start: back-to-back runs.
        fault_m = '0;
        start_m = 1'b1;
        tick();
        c = 1;
        while (!done_m && c < 120) begin
            tick();
            c++;
        end
        check("held done1_cycle", c, 49);
        tick();
        check("held gap_busy", busy_m, 0);
        check("held gap_pass", pass_m, 1);
        fault_m = 48'h1 << 15;
        tick();
        check("held run2_busy", busy_m, 1);
        check("held run2_pass_clr", pass_m, 0);
        check("held run2_vec", vec_m, 0);
        c = 51;
        while (!done_m && c < 200) begin
            tick();
            c++;
        end
        check("held done2_cycle", c, 99);
        check("held run2_err", err_m, 1);
        check("held run2_first", first_m, 5);
        tick();
        tick();
        check("held run3_busy", busy_m, 1);
        check("held run3_err_clr", err_m, 0);
        start_m = 1'b0;

        // Reset in the middle of run 3 (cycle 20 of that run).
        for (c = 102; c <= 120; c++) tick();
        check("pre_rst err", err_m, 1);
        reset_b = 1'b0;
        #1 check_reset_vals("midrun_rst");
        tick();
        tick();
        #2 reset_b = 1'b1;
        ndone = 0;
        for (c = 0; c < 60; c++) begin
            if (done_m || busy_m) ndone++;
            tick();
        end
        check("after_rst no_activity", ndone, 0);
        run_main("restart", 48'h0, 0, 0, 1'b1, s_gold);

        // All-fail table.
        start_f = 1'b1;
        tick();
        start_f = 1'b0;
        c = 1;
        while (!done_f && c < 120) begin
            tick();
            c++;
        end
        check("ff done_cycle", c, 49);
        check("ff err", err_f, 16);
        check("ff first", first_f, 0);
        check("ff sig", sig_f, 8'h00);
        tick();
        check("ff pass", pass_f, 0);

        // SETTLE=1 with corrupted response in each settle cycle.
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        bad = 0;
        for (c = 1; c <= 32; c++) begin
            glitch = c[0];
            if (vec_s != 4'((c - 1) / 2) || !busy_s) bad++;
            tick();
        end
        glitch = 1'b0;
        check("s1 vec_hold_2", bad, 0);
        check("s1 done_cycle33", done_s, 1);
        check("s1 err", err_s, 0);
        check("s1 sig", sig_s, s_gold);
        tick();
        check("s1 pass", pass_s, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
